// File: rtl/led_sched_pkg.sv
// Shared definitions for the LED pattern scheduler.
//   mode_e  : per-source pattern code (solid / slow / fast / alternate)
//   state_e : scheduler state (IDLE heartbeat, SHOW granted pattern)
//   onehot(): index to one-hot vector, truncated by callers to N_REQ bits
//   imax()  : elaboration-time helper for counter sizing
package led_sched_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID = 2'b00,
        MODE_SLOW  = 2'b01,
        MODE_FAST  = 2'b10,
        MODE_ALT   = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_e;

    localparam int unsigned MAX_REQ = 32;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter for the LED scheduler.
// Picks the first set bit of pending_i, searching upward from the pointer
// with wrap-around. The pointer moves to winner+1 when accept_i is strobed.
// Ports:
//   clk_i      system clock
//   rst_i      synchronous reset, active-high (pointer back to index 0)
//   pending_i  N_REQ request vector
//   accept_i   winner taken this cycle; advance pointer
//   valid_o    at least one request pending
//   winner_o   index of the selected request
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REQ-1:0]         pending_i,
    input  logic                     accept_i,
    output logic                     valid_o,
    output logic [$clog2(N_REQ)-1:0] winner_o
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W:0]   N_EXT = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(N_REQ-1);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] rot;
    logic [IDX_W-1:0] off;
    logic [IDX_W:0]   sum;

    // Rotate so the pointer position lands on bit 0; lowest set bit is then
    // the round-robin winner, expressed as an offset from the pointer.
    assign rot = N_REQ'({pending_i, pending_i} >> ptr_q);

    always_comb begin
        valid_o = 1'b0;
        off     = '0;
        for (int k = N_REQ-1; k >= 0; k--) begin
            if (rot[k]) begin
                valid_o = 1'b1;
                off     = IDX_W'(k);
            end
        end
    end

    assign sum      = {1'b0, ptr_q} + {1'b0, off};
    assign winner_o = (sum >= N_EXT) ? IDX_W'(sum - N_EXT) : sum[IDX_W-1:0];
    assign ptr_d    = (winner_o == LAST) ? '0 : winner_o + IDX_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (accept_i) begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Shares two status LEDs between N_REQ event sources. Idle shows a 1 Hz
// heartbeat; an event pulse queues a per-source pattern that is displayed
// for HOLD_TICKS pattern ticks once granted by a round-robin arbiter.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous reset, active-high; aborts display, drops pending
//   req_i    single-cycle event pulses, one bit per source
//   mode_i   pattern code per source, mode_i[2i+1:2i], sampled at grant
//   grant_o  one-hot current owner, 0 while idle
//   busy_o   1 while a source owns the LEDs
//   led1_o   LED 1 drive, registered
//   led2_o   LED 2 drive, registered
//
// state | meaning
// IDLE  | heartbeat on the LEDs, phase counts 0..TICK_HZ-1
// SHOW  | granted pattern on the LEDs, phase counts 0..BLINK_TICKS-1,
//       | hold down-counter expires after HOLD_TICKS ticks
module led_pattern_scheduler
    import led_sched_pkg::*;
#(
    parameter int CLK_HZ      = 12_000_000,
    parameter int TICK_HZ     = 100,
    parameter int N_REQ       = 4,
    parameter int HOLD_TICKS  = 50,
    parameter int BLINK_TICKS = 50
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [2*N_REQ-1:0] mode_i,
    output logic [N_REQ-1:0]   grant_o,
    output logic               busy_o,
    output logic               led1_o,
    output logic               led2_o
);

    localparam int PRE_DIV = CLK_HZ / TICK_HZ;
    localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
    localparam int PH_W    = $clog2(imax(TICK_HZ, BLINK_TICKS));
    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int IDX_W   = $clog2(N_REQ);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRE_DIV - 1);
    localparam logic [PH_W-1:0]   HB_LAST   = PH_W'(TICK_HZ - 1);
    localparam logic [PH_W-1:0]   HB_HALF   = PH_W'(TICK_HZ / 2);
    localparam logic [PH_W-1:0]   BL_LAST   = PH_W'(BLINK_TICKS - 1);
    localparam logic [PH_W-1:0]   BL_HALF   = PH_W'(BLINK_TICKS / 2);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_TICKS);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              tick;
    logic [N_REQ-1:0]  pending_q, pending_d, clr;
    state_e            state_q;
    logic [PH_W-1:0]   phase_q;
    logic [HOLD_W-1:0] hold_q;
    mode_e             mode_q, mode_sel;
    logic [N_REQ-1:0]  grant_q;
    logic              busy_q, led1_q, led2_q;
    logic              led1_nx, led2_nx;
    logic              arb_valid;
    logic [IDX_W-1:0]  arb_winner;
    logic [N_REQ-1:0]  win_oh;
    logic              hold_end, accept;

    assign tick  = (pre_q == PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + PRE_W'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .pending_i (pending_q),
        .accept_i  (accept),
        .valid_o   (arb_valid),
        .winner_o  (arb_winner)
    );

    assign win_oh   = N_REQ'(onehot(5'(arb_winner)));
    assign hold_end = (state_q == SHOW) && tick && (hold_q == HOLD_ONE);
    // A grant happens leaving IDLE or back-to-back at the end of a hold.
    assign accept   = arb_valid && ((state_q == IDLE) || hold_end);

    // New request wins over the grant clear on the same index, so an owner
    // pulsing again during its own grant edge is re-queued.
    assign clr       = accept ? win_oh : '0;
    assign pending_d = (pending_q & ~clr) | req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        mode_sel = MODE_SOLID;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_winner == IDX_W'(i)) begin
                mode_sel = mode_e'(mode_i[2*i +: 2]);
            end
        end
    end

    always_comb begin
        led1_nx = 1'b0;
        led2_nx = 1'b1;
        if (state_q == IDLE) begin
            led1_nx = (phase_q >= HB_HALF);
            led2_nx = ~(phase_q >= HB_HALF);
        end else begin
            case (mode_q)
                MODE_SOLID: begin
                    led1_nx = 1'b1;
                    led2_nx = 1'b1;
                end
                MODE_SLOW: begin
                    led1_nx = (phase_q >= BL_HALF);
                    led2_nx = 1'b0;
                end
                MODE_FAST: begin
                    led1_nx = phase_q[0];
                    led2_nx = 1'b0;
                end
                default: begin
                    led1_nx = (phase_q >= BL_HALF);
                    led2_nx = ~(phase_q >= BL_HALF);
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            phase_q <= '0;
            hold_q  <= '0;
            mode_q  <= MODE_SOLID;
            grant_q <= '0;
            busy_q  <= 1'b0;
            led1_q  <= 1'b0;
            led2_q  <= 1'b1;
        end else begin
            // LEDs follow the pre-edge state/phase: one registered stage of lag.
            led1_q <= led1_nx;
            led2_q <= led2_nx;
            if (accept) begin
                state_q <= SHOW;
                grant_q <= win_oh;
                busy_q  <= 1'b1;
                mode_q  <= mode_sel;
                hold_q  <= HOLD_INIT;
                phase_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (tick) begin
                            phase_q <= (phase_q == HB_LAST) ? '0 : phase_q + PH_W'(1);
                        end
                    end
                    SHOW: begin
                        if (hold_end) begin
                            state_q <= IDLE;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                            phase_q <= '0;
                        end else if (tick) begin
                            hold_q  <= hold_q - HOLD_W'(1);
                            phase_q <= (phase_q == BL_LAST) ? '0 : phase_q + PH_W'(1);
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign grant_o = grant_q;
    assign busy_o  = busy_q;
    assign led1_o  = led1_q;
    assign led2_o  = led2_q;

endmodule
